// File: rtl/shift_scheduler_pkg.sv
// shift_pkg: op encoding, widths and stage-1 payload shared by the shift scheduler slice
package shift_pkg;
  localparam int W = 32;
  localparam int SHW = 5;
  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_t;
  typedef struct packed {
    logic           id;
    op_t            op;
    logic [W-1:0]   data;
    logic [SHW-1:0] shamt;
  } s1_t;
  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/shift_scheduler_if.sv
// shift_scheduler_if: two-requester shift request channel plus shared tagged response channel
interface shift_scheduler_if;
  import shift_pkg::*;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  op_t  [1:0]          req_op;
  logic [1:0][W-1:0]   req_data;
  logic [1:0][SHW-1:0] req_shamt;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [W-1:0]        rsp_data;
  modport master (
    output req_valid, req_op, req_data, req_shamt, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );
  modport slave (
    input  req_valid, req_op, req_data, req_shamt, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_scheduler_shift_unit.sv
// shift_unit: combinational 16/8/4/2/1 barrel shifter; SLL reuses the right-shift path on reversed bits
module shift_unit
  import shift_pkg::*;
(
  input  op_t            op,
  input  logic [W-1:0]   data,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   result
);
  logic         left;
  logic         fill;
  logic [W-1:0] v;
  assign left = op == OP_SLL;
  assign fill = op == OP_SRA && data[W-1];
  always_comb begin
    v = left ? rev(data) : data;
    v = shamt[4] ? {{16{fill}}, v[W-1:16]} : v;
    v = shamt[3] ? {{8{fill}}, v[W-1:8]} : v;
    v = shamt[2] ? {{4{fill}}, v[W-1:4]} : v;
    v = shamt[1] ? {{2{fill}}, v[W-1:2]} : v;
    v = shamt[0] ? {fill, v[W-1:1]} : v;
    result = op == OP_PASS ? data : left ? rev(v) : v;
  end
endmodule

// File: rtl/shift_scheduler.sv
// shift_scheduler: round-robin sharing of one barrel shifter between two requesters
// through a two-stage pipeline with full backpressure and id-tagged responses
module shift_scheduler
  import shift_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  shift_scheduler_if.slave bus
);
  logic         prio;
  logic         gnt;
  logic         any;
  logic         accept;
  logic         s1_valid;
  logic         s2_valid;
  logic         s1_free;
  logic         s2_load;
  s1_t          s1;
  logic [W-1:0] result;
  assign any = |bus.req_valid;
  assign gnt = &bus.req_valid ? prio : bus.req_valid[1];
  assign s2_load = !s2_valid || bus.rsp_ready;
  assign s1_free = !s1_valid || s2_load;
  assign bus.req_ready = (any && s1_free && reset_n) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign accept = |(bus.req_valid & bus.req_ready);
  assign bus.rsp_valid = s2_valid;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prio         <= 1'b0;
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      bus.rsp_id   <= 1'b0;
      bus.rsp_data <= '0;
    end else begin
      if (accept) prio <= !gnt;
      if (accept) s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) s2_valid <= s1_valid;
      if (s1_valid && s2_load) begin
        bus.rsp_id   <= s1.id;
        bus.rsp_data <= result;
      end
    end
  end
  // payload register needs no reset: accept is blocked while reset_n is low
  always_ff @(posedge clock) begin
    if (accept) s1 <= '{id: gnt, op: bus.req_op[gnt], data: bus.req_data[gnt], shamt: bus.req_shamt[gnt]};
  end
  shift_unit u_shift (
    .op    (s1.op),
    .data  (s1.data),
    .shamt (s1.shamt),
    .result(result)
  );
endmodule

// File: tb/tb_shift_scheduler.sv
// tb_shift_scheduler: directed vectors, multi-cycle corner sequences and a random run
// checked every cycle against a queue-based model of the scheduler
module tb_shift_scheduler;
  import shift_pkg::*;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  shift_scheduler_if bus();
  shift_scheduler dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );
  always #5 clock = ~clock;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          t;
  } inflight_t;
  typedef struct {
    op_t         op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] res;
  } vec_t;

  inflight_t q[$];
  logic      mprio = 1'b0;
  int        waits[2] = '{0, 0};

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // reference model: in-flight queue ordered by acceptance, visible two edges after accept
  always @(negedge clock) begin
    logic [1:0] v;
    logic [1:0] er;
    logic       g;
    logic       vis;
    cyc++;
    v = bus.req_valid;
    if (!reset_n) begin
      chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
      q.delete();
      mprio = 1'b0;
      waits = '{0, 0};
    end else begin
      g = &v ? mprio : v[1];
      er = (|v && (q.size() < 2 || bus.rsp_ready)) ? (g ? 2'b10 : 2'b01) : 2'b00;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      vis = q.size() > 0 && q[0].t + 2 <= cyc;
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(vis));
      if (vis) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
        chk("rsp_data", bus.rsp_data, q[0].data);
        if (bus.rsp_ready) void'(q.pop_front());
      end
      if (er != 2'b00) begin
        q.push_back('{g, ref_shift(bus.req_op[g], bus.req_data[g], bus.req_shamt[g]), cyc});
        for (int i = 0; i < 2; i++) begin
          if (!v[i]) waits[i] = 0;
          else if (i == 32'(g)) waits[i] = 0;
          else begin
            waits[i]++;
            chk("grant_wait", 32'(waits[i] <= 1), 32'd1);
          end
        end
        mprio = !g;
      end else begin
        for (int i = 0; i < 2; i++) if (!v[i]) waits[i] = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[11];
    logic [31:0] got[$];
    logic [31:0] want[3];
    logic [1:0]  acc;
    logic        a0;
    int          n;
    tbl[0]  = '{OP_SRA,  32'h80000000, 5'd4,  32'hF8000000};
    tbl[1]  = '{OP_SRL,  32'h80000000, 5'd4,  32'h08000000};
    tbl[2]  = '{OP_SLL,  32'h00000001, 5'd31, 32'h80000000};
    tbl[3]  = '{OP_SRA,  32'h7FFFFFFF, 5'd31, 32'h00000000};
    tbl[4]  = '{OP_SLL,  32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    tbl[5]  = '{OP_SRL,  32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    tbl[6]  = '{OP_SRA,  32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    tbl[7]  = '{OP_PASS, 32'hDEADBEEF, 5'd9,  32'hDEADBEEF};
    tbl[8]  = '{OP_SRA,  32'h80000000, 5'd31, 32'hFFFFFFFF};
    tbl[9]  = '{OP_SLL,  32'h0000F00F, 5'd13, 32'h1E01E000};
    tbl[10] = '{OP_SRL,  32'hFFFFFFFF, 5'd17, 32'h00007FFF};
    want = '{32'h11, 32'h22, 32'h33};
    bus.req_valid = 2'b11;
    bus.req_op[0] = OP_SLL;
    bus.req_op[1] = OP_SLL;
    bus.req_data = '0;
    bus.req_shamt = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) tick();
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      tick();
      bus.req_op[0] = tbl[i].op;
      bus.req_data[0] = tbl[i].data;
      bus.req_shamt[0] = tbl[i].shamt;
      bus.req_valid = 2'b01;
      #1;
      chk("tbl_ready", 32'(bus.req_ready), 32'd1);
      tick();
      bus.req_valid = 2'b00;
      tick();
      #1;
      chk("tbl_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tbl_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("tbl_rsp_data", bus.rsp_data, tbl[i].res);
    end

    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.req_op[0] = OP_SRL;
    bus.req_op[1] = OP_SRA;
    bus.req_shamt[0] = 5'd3;
    bus.req_shamt[1] = 5'd5;
    bus.req_data[0] = $urandom;
    bus.req_data[1] = $urandom;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        tick();
        if (k <= 6) bus.req_data[(k - 1) % 2] = $urandom;
        if (k == 6) bus.req_valid = 2'b00;
      end
      #1;
      if (k < 6) chk("rr_grant", 32'(bus.req_ready), (k % 2 != 0) ? 32'd2 : 32'd1);
      if (k >= 2) begin
        chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rr_rsp_id", 32'(bus.rsp_id), 32'((k - 2) % 2));
      end
    end

    tick();
    bus.rsp_ready = 1'b0;
    bus.req_op[0] = OP_PASS;
    bus.req_shamt[0] = 5'd7;
    bus.req_data[0] = 32'h11;
    bus.req_valid = 2'b01;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      a0 = bus.req_ready[0];
      tick();
      if (a0) begin
        n++;
        bus.req_data[0] = (n == 1) ? 32'h22 : 32'h33;
      end
    end
    #1;
    chk("bp_accepted", 32'(n), 32'd2);
    chk("bp_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rsp_data", bus.rsp_data, 32'h11);
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("bp_hold", bus.rsp_data, 32'h11);
    end
    bus.rsp_ready = 1'b1;
    #1;
    got.delete();
    for (int k = 0; k < 8; k++) begin
      if (bus.rsp_valid && bus.rsp_ready) got.push_back(bus.rsp_data);
      a0 = bus.req_valid[0] && bus.req_ready[0];
      tick();
      if (a0) bus.req_valid = 2'b00;
      #1;
    end
    chk("bp_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) if (i < got.size()) chk("bp_order", got[i], want[i]);

    tick();
    bus.rsp_ready = 1'b0;
    bus.req_op[0] = OP_PASS;
    bus.req_op[1] = OP_PASS;
    bus.req_data[0] = 32'hA0;
    bus.req_data[1] = 32'hB1;
    bus.req_valid = 2'b11;
    repeat (3) tick();
    #1;
    chk("rst_full_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rst_full_ready", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst_ready_low", 32'(bus.req_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_rsp_cleared", 32'(bus.rsp_valid), 32'd0);
    chk("rst_first_grant", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("rst_no_stale", 32'(bus.rsp_valid), 32'd0);
    tick();
    #1;
    chk("rst_new_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rst_new_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_new_data", bus.rsp_data, 32'hA0);
    tick();
    #1;
    chk("rst_drained", 32'(bus.rsp_valid), 32'd0);

    for (int k = 0; k < 10000; k++) begin
      acc = bus.req_valid & bus.req_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = $urandom_range(0, 3) != 0;
          bus.req_op[i] = op_t'($urandom_range(0, 3));
          bus.req_data[i] = $urandom;
          bus.req_shamt[i] = 5'($urandom);
        end
      end
      bus.rsp_ready = $urandom_range(0, (k < 5000) ? 3 : 1) != 0;
      reset_n = $urandom_range(0, 999) != 0;
      #1;
    end

    tick();
    reset_n = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (5) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
